// File: rtl/multicycle_ctrl_if.sv
// Unified memory-port handshake between the multi-cycle control FSM and the memory.
// The controller drives request/write/address-select; the memory answers with ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I datapath (lw, sw, OP-IMM, OP, branches).
// Optional feature: define ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky TRAP state.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              opcode,
    multicycle_ctrl_if.master       mem,
    output logic                    pc_write,
    output logic                    branch,
    output logic                    ir_write,
    output logic                    reg_write,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              result_src,
    output logic                    instr_retired,
    output logic                    bus_err,
    output logic                    illegal
);

    localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req;
    logic               timeout;
    logic               mem_req_o, mem_we_o, adr_src_o;

    assign req     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // Completion has priority: the limit only fires while the memory is still not ready.
    assign timeout = (MEM_TIMEOUT != 0) && req && !mem.mem_ready
                     && (cnt_q == CNT_W'(MEM_TIMEOUT));

    assign mem.mem_req = mem_req_o;
    assign mem.mem_we  = mem_we_o;
    assign mem.adr_src = adr_src_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        adr_src_o     = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        instr_retired = 1'b0;
        bus_err       = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req_o  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem.mem_ready) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_err  = 1'b1;
                    state_d  = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch target (old PC + imm) is computed here into the ALU-out register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
                    OPC_OPIMM:           state_d = S_EXEC_I;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_BRANCH:          state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_d = S_TRAP;
`else
                    default:             state_d = S_FETCH;
`endif
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end

            S_MEMWR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adr_src_o = 1'b1;
                if (mem.mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a     = 2'b10;
                alu_op        = 2'b01;
                branch        = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end

            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_d = S_TRAP;
`else
                state_d = S_IDLE;
`endif
            end

            default: state_d = S_IDLE;
        endcase

        // Wait counter restarts on any state change, including a timeout re-entering FETCH.
        cnt_d = cnt_q;
        if ((state_d != state_q) || timeout) begin
            cnt_d = '0;
        end else if (req && !mem.mem_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction
// streams, each compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    // Output word: {pc_write, branch, ir_write, adr_src, mem_req, mem_we, reg_write,
    //               alu_src_a, alu_src_b, alu_op, result_src, instr_retired, bus_err, illegal}
    localparam logic [17:0] V_IDLE   = 18'd0;
    localparam logic [17:0] V_FETCH  = {7'b0000100, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000};
    localparam logic [17:0] V_DECODE = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMADR = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMRD  = {7'b0001100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMWB  = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b100};
    localparam logic [17:0] V_MEMWR  = {7'b0001110, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [17:0] V_EXEC_R = {7'b0000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [17:0] V_EXEC_I = {7'b0000000, 2'b10, 2'b01, 2'b10, 2'b00, 3'b000};
    localparam logic [17:0] V_ALUWB  = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100};
    localparam logic [17:0] V_BRANCH = {7'b0100000, 2'b10, 2'b00, 2'b01, 2'b00, 3'b100};
    localparam logic [17:0] V_TRAP   = 18'd1;
    localparam logic [17:0] X_PCIR   = {1'b1, 1'b0, 1'b1, 15'd0};
    localparam logic [17:0] X_RET    = 18'd4;
    localparam logic [17:0] X_BERR   = 18'd2;
    localparam logic [17:0] X_NONE   = 18'd0;

    typedef struct packed {
        logic [6:0] op;
        logic       rdy;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        pc_write, branch, ir_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        instr_retired, bus_err, illegal;

    stim_t       stim_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] expd_q[$];
    logic [17:0] act_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem           (bus.master),
        .pc_write      (pc_write),
        .branch        (branch),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .instr_retired (instr_retired),
        .bus_err       (bus_err),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] outs();
        return {pc_write, branch, ir_write, bus.adr_src, bus.mem_req, bus.mem_we, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_retired, bus_err, illegal};
    endfunction

    // ---------------- reference model (instruction level) ----------------
    task automatic push(input logic [6:0] op, input logic rdy, input logic [17:0] v);
        stim_t s;
        s.op  = op;
        s.rdy = rdy;
        stim_q.push_back(s);
        exp_q.push_back(v);
    endtask

    // A memory access waits w not-ready cycles; the (TO+1)-th not-ready cycle is a timeout.
    task automatic add_mem(input logic [6:0] op, input logic [17:0] base, input logic [17:0] extra,
                           input int w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            if (i == w) begin
                push(op, 1'b1, base | extra);
                ok = 1'b1;
                return;
            end
            if (i == TO) begin
                push(op, 1'b0, base | X_BERR);
                return;
            end
            push(op, 1'b0, base);
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input int fw, input int dw);
        bit ok;
        add_mem(op, V_FETCH, X_PCIR, fw, ok);
        if (!ok) return;
        push(op, 1'($urandom_range(0, 1)), V_DECODE);
        case (op)
            OPC_LOAD: begin
                push(op, 1'($urandom_range(0, 1)), V_MEMADR);
                add_mem(op, V_MEMRD, X_NONE, dw, ok);
                if (ok) push(op, 1'($urandom_range(0, 1)), V_MEMWB);
            end
            OPC_STORE: begin
                push(op, 1'($urandom_range(0, 1)), V_MEMADR);
                add_mem(op, V_MEMWR, X_RET, dw, ok);
            end
            OPC_OPIMM: begin
                push(op, 1'($urandom_range(0, 1)), V_EXEC_I);
                push(op, 1'($urandom_range(0, 1)), V_ALUWB);
            end
            OPC_OP: begin
                push(op, 1'($urandom_range(0, 1)), V_EXEC_R);
                push(op, 1'($urandom_range(0, 1)), V_ALUWB);
            end
            OPC_BRANCH: push(op, 1'($urandom_range(0, 1)), V_BRANCH);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 5; i++) push(op, 1'($urandom_range(0, 1)), V_TRAP);
`endif
            end
        endcase
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst_n         = 1'b0;
        opcode        = 7'd0;
        bus.mem_ready = 1'b0;
        stim_q.delete();
        exp_q.delete();
        expd_q.delete();
        act_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(7'd0, 1'($urandom_range(0, 1)), V_IDLE);
    endtask

    task automatic play(input int n);
        stim_t s;
        for (int i = 0; i < n && stim_q.size() > 0; i++) begin
            s             = stim_q.pop_front();
            opcode        = s.op;
            bus.mem_ready = s.rdy;
            #1;
            act_q.push_back(outs());
            expd_q.push_back(exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        opcode = OPC_LOAD;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (outs() !== 18'd0) $display("FAIL reset_outs cyc %0d: got %h expected %h", i, outs(), 18'd0);
            else n_pass++;
        end
        do_reset();
        add_instr(OPC_BRANCH, 0, 0);
        play(1000);
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL reset_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_alu_imm();
        do_reset();
        add_instr(OPC_OPIMM, 0, 0);
        add_instr(OPC_OP, 0, 0);
        play(1000);
        n_checks++;
        if ({act_q[4][11], act_q[4][2]} !== 2'b11)
            $display("FAIL alui_wb_cycle5: got rw/ret %b expected 11", {act_q[4][11], act_q[4][2]});
        else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL alu_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_load_wait();
        int nreq;
        do_reset();
        add_instr(OPC_LOAD, 0, 3);
        play(1000);
        nreq = 0;
        foreach (act_q[i]) if (act_q[i][14] && act_q[i][13]) nreq++;
        n_checks++;
        if (nreq != 4) $display("FAIL load_req_cycles: got %0d expected 4", nreq);
        else n_pass++;
        n_checks++;
        if ({act_q[8][4:3], act_q[8][11]} !== 3'b011)
            $display("FAIL load_memwb: got rs/rw %b expected 011", {act_q[8][4:3], act_q[8][11]});
        else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL load_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_store();
        int nrw;
        do_reset();
        add_instr(OPC_STORE, 1, 2);
        play(1000);
        nrw = 0;
        foreach (act_q[i]) if (act_q[i][11]) nrw++;
        n_checks++;
        if (nrw != 0) $display("FAIL store_regwrite: got %0d cycles expected 0", nrw);
        else n_pass++;
        n_checks++;
        if ({act_q[7][13], act_q[7][12], act_q[7][2]} !== 3'b111)
            $display("FAIL store_ready_cycle: got req/we/ret %b expected 111",
                     {act_q[7][13], act_q[7][12], act_q[7][2]});
        else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL store_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int nberr;
        do_reset();
        add_instr(OPC_OPIMM, TO + 1, 0);
        add_instr(OPC_OPIMM, TO, 0);
        add_instr(OPC_STORE, 0, TO + 2);
        play(1000);
        nberr = 0;
        for (int i = 1; i <= TO + 1; i++) if (act_q[i][1]) nberr++;
        n_checks++;
        if (nberr != 1) $display("FAIL timeout_berr_count: got %0d expected 1", nberr);
        else n_pass++;
        n_checks++;
        if ({act_q[TO + 1][17], act_q[TO + 1][15]} !== 2'b00)
            $display("FAIL timeout_no_pcir: got %b expected 00", {act_q[TO + 1][17], act_q[TO + 1][15]});
        else n_pass++;
        n_checks++;
        if ({act_q[2 * TO + 2][13], act_q[2 * TO + 2][1], act_q[2 * TO + 2][17]} !== 3'b101)
            $display("FAIL timeout_limit_ready: got req/berr/pcw %b expected 101",
                     {act_q[2 * TO + 2][13], act_q[2 * TO + 2][1], act_q[2 * TO + 2][17]});
        else n_pass++;
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL timeout_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        do_reset();
        add_instr(OPC_BAD, 0, 0);
`ifndef ILLEGAL_TRAP_EN
        add_instr(OPC_BRANCH, 0, 0);
`endif
        play(1000);
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL illegal_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (illegal !== 1'b0) $display("FAIL illegal_cleared_by_reset: got %b expected 0", illegal);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int nret;
        do_reset();
        add_instr(OPC_STORE, 0, 3);
        play(5);
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b1) $display("FAIL arst_in_memwr: got mem_we %b expected 1", bus.mem_we);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0) $display("FAIL arst_we_drop: got %b expected 0", bus.mem_we);
        else n_pass++;
        n_checks++;
        if (outs() !== 18'd0) $display("FAIL arst_all_zero: got %h expected %h", outs(), 18'd0);
        else n_pass++;
        nret = 0;
        foreach (act_q[i]) if (act_q[i][2]) nret++;
        n_checks++;
        if (nret != 0) $display("FAIL arst_no_retire: got %0d expected 0", nret);
        else n_pass++;
        @(negedge clk);
        do_reset();
        add_instr(OPC_STORE, 0, TO);
        play(1000);
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL arst_restart cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        int fw, dw;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 5))
                0: op = OPC_LOAD;
                1: op = OPC_STORE;
                2: op = OPC_OPIMM;
                3: op = OPC_OP;
                4: op = OPC_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                default: op = OPC_OPIMM;
`else
                default: op = 7'($urandom_range(0, 1) ? 32'h7f : 32'h33 ^ 32'h40);
`endif
            endcase
            fw = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            dw = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            add_instr(op, fw, dw);
        end
        play(100000);
        for (int i = 0; i < act_q.size(); i++) begin
            n_checks++;
            if (act_q[i] !== expd_q[i]) $display("FAIL random_seq cyc %0d: got %h expected %h", i, act_q[i], expd_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        opcode        = 7'd0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_imm();
        test_load_wait();
        test_store();
        test_timeout();
        test_illegal();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
